// File: rtl/load_register.sv
// Enable-gated D register with synchronous clear and load-valid flag.
// Optional even-parity bit enabled by defining LOAD_REGISTER_PARITY_EN.
module load_register #(
  parameter int unsigned            REG_WIDTH   = 16,
  parameter logic [REG_WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [REG_WIDTH-1:0] din,
  output logic [REG_WIDTH-1:0] dout,
`ifdef LOAD_REGISTER_PARITY_EN
  output logic                 vld,
  output logic                 par
`else
  output logic                 vld
`endif
);

  // reset and clear share one path; clear wins over load
  logic wipe;
  assign wipe = !rst || clr;

  // data storage: wipe to RESET_VALUE, load on en, else hold
  always_ff @(posedge clk) begin
    if (wipe) begin
      dout <= RESET_VALUE;
    end else if (en) begin
      dout <= din;
    end
  end

  // valid flag: set by any load, dropped by reset or clear
  always_ff @(posedge clk) begin
    if (wipe) begin
      vld <= 1'b0;
    end else if (en) begin
      vld <= 1'b1;
    end
  end

`ifdef LOAD_REGISTER_PARITY_EN
  // parity tracks dout under identical priority, so par == ^dout
  always_ff @(posedge clk) begin
    if (wipe) begin
      par <= ^RESET_VALUE;
    end else if (en) begin
      par <= ^din;
    end
  end

  // simulation check that the parity flop never drifts from dout
  always @(posedge clk) begin
    if (!$isunknown({par, dout})) begin
      assert (par == ^dout)
        else $error("parity bit disagrees with dout");
    end
  end
`endif

endmodule

// File: tb/tb_load_register.sv
// Bench for load_register: directed steps then random traffic
// against an array model of a single register and an 8-deep chain.
module tb_load_register;

  localparam int W = 5;
  localparam int N = 8;
  localparam logic [W-1:0] RV2 = 5'h11;

  logic         clk = 1'b0;
  logic         rst, en, clr, en_c;
  logic [W-1:0] din, din_c;
  logic [W-1:0] dout, dout2;
  logic         vld, vld2;
  logic [W-1:0] c_out [N];
  logic         c_vld [N];
`ifdef LOAD_REGISTER_PARITY_EN
  logic         par, par2;
  logic         c_par [N];
`endif

  int total = 0;
  int bad   = 0;

  // model state
  logic [W-1:0] m_val, m_val2;
  logic         m_vld;
  logic [W-1:0] m_ch [N];
  logic         m_chv;

  always #5 clk = ~clk;

  load_register #(.REG_WIDTH(W), .RESET_VALUE(5'h00)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din),
    .dout(dout),
`ifdef LOAD_REGISTER_PARITY_EN
    .par(par),
`endif
    .vld(vld)
  );

  load_register #(.REG_WIDTH(W), .RESET_VALUE(RV2)) u_rv (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din),
    .dout(dout2),
`ifdef LOAD_REGISTER_PARITY_EN
    .par(par2),
`endif
    .vld(vld2)
  );

  for (genvar k = 0; k < N; k++) begin : g_chain
    logic [W-1:0] d_in;
    if (k == 0) begin : g_head
      assign d_in = din_c;
    end else begin : g_body
      assign d_in = c_out[k-1];
    end
    load_register #(.REG_WIDTH(W), .RESET_VALUE(5'h00)) u_st (
      .clk(clk), .rst(rst), .en(en_c), .clr(clr), .din(d_in),
      .dout(c_out[k]),
`ifdef LOAD_REGISTER_PARITY_EN
      .par(c_par[k]),
`endif
      .vld(c_vld[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // one clock: model follows the stated priority rules, then compare
  task automatic tick();
    @(posedge clk);
    if (!rst || clr) begin
      m_val  = 5'h00;
      m_val2 = RV2;
      m_vld  = 1'b0;
      for (int k = 0; k < N; k++) m_ch[k] = 5'h00;
      m_chv  = 1'b0;
    end else begin
      if (en) begin
        m_val  = din;
        m_val2 = din;
        m_vld  = 1'b1;
      end
      if (en_c) begin
        for (int k = N - 1; k > 0; k--) m_ch[k] = m_ch[k-1];
        m_ch[0] = din_c;
        m_chv   = 1'b1;
      end
    end
    #1;
    chk("dout", 32'(dout), 32'(m_val));
    chk("vld", 32'(vld), 32'(m_vld));
    chk("dout_rv", 32'(dout2), 32'(m_val2));
    chk("vld_rv", 32'(vld2), 32'(m_vld));
`ifdef LOAD_REGISTER_PARITY_EN
    chk("par", 32'(par), 32'(^m_val));
    chk("par_rv", 32'(par2), 32'(^m_val2));
`endif
    for (int k = 0; k < N; k++) begin
      chk($sformatf("chain%0d", k), 32'(c_out[k]), 32'(m_ch[k]));
    end
  endtask

  initial begin
    logic [W-1:0] hist [$];
    rst = 1'b0; en = 1'b1; clr = 1'b0; din = 5'h1F;
    en_c = 1'b0; din_c = 5'h00;
    m_val = 'x; m_val2 = 'x; m_vld = 1'bx; m_chv = 1'bx;

    // reset for two edges with en high
    tick();
    tick();
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_vld", 32'(vld), 32'h0);
    chk("rst_dout_rv", 32'(dout2), 32'h11);
`ifdef LOAD_REGISTER_PARITY_EN
    chk("rst_par", 32'(par), 32'h0);
`endif

    // load then hold
    rst = 1'b1; en = 1'b1; din = 5'h0A;
    tick();
    chk("load", 32'(dout), 32'h0A);
    chk("load_vld", 32'(vld), 32'h1);
    en = 1'b0; din = 5'h15;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold", 32'(dout), 32'h0A);
      chk("hold_vld", 32'(vld), 32'h1);
    end

    // clear beats load
    en = 1'b1; clr = 1'b1; din = 5'h07;
    tick();
    chk("clr_dout", 32'(dout), 32'h0);
    chk("clr_vld", 32'(vld), 32'h0);
    chk("clr_dout_rv", 32'(dout2), 32'h11);
    clr = 1'b0;
    tick();
    chk("after_clr", 32'(dout), 32'h07);
    chk("after_clr_vld", 32'(vld), 32'h1);

    // reset mid-stream
    din = 5'h0A;
    tick();
    chk("pre_rst", 32'(dout), 32'h0A);
    rst = 1'b0;
    tick();
    chk("mid_rst", 32'(dout), 32'h0);
    chk("mid_rst_rv", 32'(dout2), 32'h11);
    chk("mid_rst_vld", 32'(vld), 32'h0);
    rst = 1'b1; en = 1'b0;
    tick();

`ifdef LOAD_REGISTER_PARITY_EN
    en = 1'b1; din = 5'h07;
    tick();
    chk("par_07", 32'(par), 32'h1);
    din = 5'h03;
    tick();
    chk("par_03", 32'(par), 32'h0);
    en = 1'b0;
`endif

    // chain shift: 8 random inputs, stage k holds input from k+1 edges ago
    en_c = 1'b1;
    for (int i = 0; i < N; i++) begin
      din_c = W'($urandom);
      hist.push_front(din_c);
      tick();
    end
    en_c = 1'b0;
    din_c = 5'h1F;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int k = 0; k < N; k++) begin
        chk($sformatf("chain_hold%0d", k), 32'(c_out[k]), 32'(hist[k]));
        chk($sformatf("chain_vld%0d", k), 32'(c_vld[k]), 32'h1);
      end
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 19) != 0);
      clr   = ($urandom_range(0, 14) == 0);
      en    = $urandom_range(0, 1) == 1;
      en_c  = $urandom_range(0, 2) != 0;
      din   = W'($urandom);
      din_c = W'($urandom);
      tick();
      for (int k = 0; k < N; k++) begin
        if (k == 0 || c_vld[k]) begin
          chk("chain_vld_r", 32'(c_vld[k]), 32'(m_chv));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
